led_pwm_ctrl: RTL and testbench



---
 rtl/led_pwm_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_led_pwm_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_ctrl
// Description : Bus-mapped multi-channel LED controller. Each channel has a
//               4-bit PWM duty and an off/steady/blink mode, with a shared
//               blink prescaler, a global enable and a channel-0 force.
//               Duty/mode writes are double-buffered to the PWM period.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_ctrl #(
    parameter int          N_CH      = 4,
    parameter logic [15:0] BASE_ADDR = 16'hD020,
    parameter int          PWM_DIV   = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     Abus,
    input  logic [7:0]      Data_In,
    input  logic            we,
    output logic [7:0]      Data_Out,
    output logic            sel,
    output logic [N_CH-1:0] LEDs
);

    localparam int             PS_W      = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PWM_DIV - 1);
    localparam logic [3:0]     OFF_CTRL  = 4'h0;
    localparam logic [3:0]     OFF_BLINK = 4'h1;
    localparam logic [1:0]     MODE_OFF    = 2'b00;
    localparam logic [1:0]     MODE_STEADY = 2'b01;
    localparam logic [1:0]     MODE_BLINK  = 2'b10;
    localparam logic [1:0]     MODE_BLINKN = 2'b11;
    localparam logic [1:0]     CTRL_RST  = 2'b11;
    localparam logic [7:0]     BLINK_RST = 8'h1F;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  we_q;
    logic [1:0]            ctrl_q,       ctrl_d;
    logic [7:0]            blink_rate_q, blink_rate_d;
    logic [N_CH-1:0][5:0]  shadow_q,     shadow_d;
    logic [N_CH-1:0][5:0]  active_q,     active_d;
    logic [PS_W-1:0]       presc_q,      presc_d;
    logic [3:0]            pwm_cnt_q,    pwm_cnt_d;
    logic [7:0]            blink_cnt_q,  blink_cnt_d;
    logic                  phase_q,      phase_d;
    logic [N_CH-1:0]       leds_q,       leds_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0]      w_off;
    logic            w_commit;
    logic            w_step;
    logic            w_boundary;
    logic            w_wr_ctrl;
    logic            w_wr_blink;
    logic [N_CH-1:0] w_wr_ch;
    logic [N_CH-1:0] w_raw;

    assign w_off      = Abus[3:0];
    assign sel        = (Abus[15:4] == BASE_ADDR[15:4]);
    // The write commits on the falling edge of the strobe, so a long strobe
    // still produces a single commit using the address/data of that cycle.
    assign w_commit   = we_q & ~we & sel;
    assign w_wr_ctrl  = w_commit && (w_off == OFF_CTRL);
    assign w_wr_blink = w_commit && (w_off == OFF_BLINK);

    assign w_step     = (presc_q == PS_LAST);
    assign w_boundary = w_step && (pwm_cnt_q == 4'hF);

    // Per-channel write hit and PWM/mode compare
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [3:0] w_duty;
            logic [1:0] w_mode;
            logic       w_on_pwm;

            assign w_wr_ch[gi] = w_commit && (w_off == 4'(gi + 2));
            assign w_duty      = active_q[gi][3:0];
            assign w_mode      = active_q[gi][5:4];
            assign w_on_pwm    = (w_duty == 4'hF) || (pwm_cnt_q < w_duty);

            // Mode selects how the PWM wave is gated by the blink phase
            always_comb begin
                w_raw[gi] = 1'b0;
                case (w_mode)
                    MODE_OFF:    w_raw[gi] = 1'b0;
                    MODE_STEADY: w_raw[gi] = w_on_pwm;
                    MODE_BLINK:  w_raw[gi] = w_on_pwm & phase_q;
                    MODE_BLINKN: w_raw[gi] = w_on_pwm & ~phase_q;
                    default:     w_raw[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    // Next-state logic for registers, counters, blink phase and LED drive
    always_comb begin
        ctrl_d       = ctrl_q;
        blink_rate_d = blink_rate_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        presc_d      = presc_q;
        pwm_cnt_d    = pwm_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        leds_d       = '0;

        if (w_wr_ctrl) begin
            ctrl_d = Data_In[1:0];
        end
        if (w_wr_blink) begin
            blink_rate_d = Data_In;
        end

        // PWM prescaler and step counter
        if (w_step) begin
            presc_d   = '0;
            pwm_cnt_d = pwm_cnt_q + 4'd1;
        end else begin
            presc_d   = presc_q + PS_W'(1);
        end

        // Blink divider runs on period boundaries; a rate write restarts it
        if (w_boundary) begin
            if (blink_cnt_q == blink_rate_q) begin
                blink_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
        if (w_wr_blink) begin
            blink_cnt_d = 8'd0;
        end

        // Shadow takes every write; active follows shadow only at the period
        // boundary, and a write landing on the boundary goes straight through.
        for (int i = 0; i < N_CH; i++) begin
            if (w_wr_ch[i]) begin
                shadow_d[i] = Data_In[5:0];
            end
            if (w_boundary) begin
                active_d[i] = w_wr_ch[i] ? Data_In[5:0] : shadow_q[i];
            end
        end

        leds_d    = w_raw & {N_CH{ctrl_q[0]}};
        leds_d[0] = leds_d[0] | ctrl_q[1];
    end

    // State registers with synchronous reset; reset also drops any strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            ctrl_q       <= CTRL_RST;
            blink_rate_q <= BLINK_RST;
            shadow_q     <= '0;
            active_q     <= '0;
            presc_q      <= '0;
            pwm_cnt_q    <= 4'd0;
            blink_cnt_q  <= 8'd0;
            phase_q      <= 1'b0;
            leds_q       <= '0;
        end else begin
            we_q         <= we;
            ctrl_q       <= ctrl_d;
            blink_rate_q <= blink_rate_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            presc_q      <= presc_d;
            pwm_cnt_q    <= pwm_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            leds_q       <= leds_d;
        end
    end

    assign LEDs = leds_q;

    // Read-back mux; channel reads return the shadow (last written) value
    always_comb begin
        Data_Out = 8'h00;
        if (sel) begin
            case (w_off)
                OFF_CTRL:  Data_Out = {6'b0, ctrl_q};
                OFF_BLINK: Data_Out = blink_rate_q;
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (w_off == 4'(i + 2)) begin
                            Data_Out = {2'b00, shadow_q[i]};
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_ctrl
// Description : Directed self-checking bench for led_pwm_ctrl (PWM_DIV=4,
//               so one PWM period is 64 clocks; boundaries fall on cycles
//               that are multiples of 64 counted from reset release).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] Abus;
    logic [7:0]  Data_In;
    logic        we;
    logic [7:0]  Data_Out;
    logic        sel;
    logic [3:0]  LEDs;

    int tests;
    int failed;
    int cyc;

    led_pwm_ctrl #(
        .N_CH      (4),
        .BASE_ADDR (16'hD020),
        .PWM_DIV   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Abus     (Abus),
        .Data_In  (Data_In),
        .we       (we),
        .Data_Out (Data_Out),
        .sel      (sel),
        .LEDs     (LEDs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
        if (cyc > target) begin
            tests++;
            failed++;
            $error("FAIL schedule: observed cycle %0d expected %0d", cyc, target);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        Abus    = a;
        Data_In = d;
        we      = 1'b1;
        tick();
        we      = 1'b0;
        tick();
        Abus    = 16'h0000;
        Data_In = 8'h00;
    endtask

    task automatic check_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        Abus = a;
        #1;
        check(tag, {24'd0, Data_Out}, {24'd0, exp});
        Abus = 16'h0000;
    endtask

    task automatic count_window(input int last, output int n0, output int n1,
                                output int n2, output int n12, output int nnz);
        n0 = 0; n1 = 0; n2 = 0; n12 = 0; nnz = 0;
        while (cyc < last) begin
            tick();
            n0  += int'(LEDs[0]);
            n1  += int'(LEDs[1]);
            n2  += int'(LEDs[2]);
            n12 += int'(LEDs[1] & LEDs[2]);
            nnz += int'(LEDs != 4'b0000);
        end
    endtask

    initial begin
        int n0, n1, n2, n12, nnz;
        tests = 0; failed = 0; cyc = 0;
        rst = 1'b1; we = 1'b0; Abus = 16'h0000; Data_In = 8'h00;

        // Reset state
        repeat (3) tick();
        check("leds_in_reset", {28'd0, LEDs}, 32'h0);
        rst = 1'b0;
        cyc = 0;
        tick();
        check("leds_after_reset", {28'd0, LEDs}, 32'h1);
        check_rd("rd_ctrl_rst",  16'hD020, 8'h03);
        check_rd("rd_blink_rst", 16'hD021, 8'h1F);
        check_rd("rd_ch0_rst",   16'hD022, 8'h00);
        Abus = 16'hD010; #1;
        check("sel_outside", {31'd0, sel}, 32'h0);
        check("rd_outside", {24'd0, Data_Out}, 32'h0);
        Abus = 16'hD02A; #1;
        check("sel_inside", {31'd0, sel}, 32'h1);
        Abus = 16'h0000;

        // CH1 steady duty 8: held off until the boundary at 64, then 8/16
        wait_until(8);
        bus_write(16'hD023, 8'h18);
        check_rd("rd_ch1", 16'hD023, 8'h18);
        count_window(64, n0, n1, n2, n12, nnz);
        check("ch1_not_mid_period", n1, 0);
        tick();
        check("ch1_first_on", {31'd0, LEDs[1]}, 32'h1);
        count_window(128, n0, n1, n2, n12, nnz);
        check("ch1_duty_66_128", n1, 31);
        check("ch0_force_on", n0, 63);

        // CH2 full on, then duty 0
        wait_until(130);
        bus_write(16'hD024, 8'h1F);
        count_window(192, n0, n1, n2, n12, nnz);
        check("ch2_wait_boundary", n2, 0);
        count_window(256, n0, n1, n2, n12, nnz);
        check("ch2_full_on", n2, 64);
        check("ch1_duty_period", n1, 32);
        wait_until(258);
        bus_write(16'hD024, 8'h10);
        count_window(320, n0, n1, n2, n12, nnz);
        check("ch2_old_until_boundary", n2, 60);
        count_window(384, n0, n1, n2, n12, nnz);
        check("ch2_duty0_off", n2, 0);

        // Blink rate 0: CH1 blink vs CH2 inverted alternate whole periods
        wait_until(386);
        bus_write(16'hD021, 8'h00);
        bus_write(16'hD023, 8'h2F);
        bus_write(16'hD024, 8'h3F);
        check_rd("rd_blink0", 16'hD021, 8'h00);
        count_window(448, n0, n1, n2, n12, nnz);
        count_window(512, n0, n1, n2, n12, nnz);
        check("blink_p1_ch1", n1, 64);
        check("blink_p1_ch2", n2, 0);
        check("blink_p1_both", n12, 0);
        count_window(576, n0, n1, n2, n12, nnz);
        check("blink_p2_ch1", n1, 0);
        check("blink_p2_ch2", n2, 64);
        check("blink_p2_both", n12, 0);

        // Global disable, then force only
        wait_until(578);
        bus_write(16'hD020, 8'h00);
        count_window(650, n0, n1, n2, n12, nnz);
        check("ctrl0_all_off", nnz, 0);
        check_rd("rd_ctrl0", 16'hD020, 8'h00);
        bus_write(16'hD020, 8'h02);
        tick();
        check("ctrl2_leds", {28'd0, LEDs}, 32'h1);
        count_window(720, n0, n1, n2, n12, nnz);
        check("ctrl2_ch0", n0, 67);
        check("ctrl2_ch1", n1, 0);
        check("ctrl2_ch2", n2, 0);
        check_rd("rd_ctrl2", 16'hD020, 8'h02);

        // Long strobe: one commit, on the falling edge
        Abus = 16'hD025; Data_In = 8'h11; we = 1'b1;
        repeat (10) tick();
        #1;
        check("long_we_no_commit", {24'd0, Data_Out}, 32'h00);
        Data_In = 8'h15; we = 1'b0;
        tick();
        Data_In = 8'h22;
        repeat (3) tick();
        check("long_we_one_commit", {24'd0, Data_Out}, 32'h15);
        Abus = 16'h0000; Data_In = 8'h00;

        // Ignored writes: unmapped offset and outside window
        bus_write(16'hD02F, 8'hAA);
        check_rd("rd_unmapped", 16'hD02F, 8'h00);
        bus_write(16'hD012, 8'h15);
        check_rd("rd_ch0_unsel_wr", 16'hD022, 8'h00);

        // Commit landing on the boundary cycle (768) goes straight to active
        wait_until(760);
        bus_write(16'hD020, 8'h01);
        wait_until(766);
        bus_write(16'hD022, 8'h1F);
        check("bnd_before", {31'd0, LEDs[0]}, 32'h0);
        tick();
        check("bnd_same_period", {31'd0, LEDs[0]}, 32'h1);
        check_rd("rd_ch0_bnd", 16'hD022, 8'h1F);

        // Reset mid-blink with a strobe in flight
        wait_until(800);
        Abus = 16'hD023; Data_In = 8'h00; we = 1'b1;
        tick();
        rst = 1'b1; we = 1'b0;
        tick();
        check("leds_mid_reset", {28'd0, LEDs}, 32'h0);
        tick();
        rst = 1'b0;
        cyc = 0;
        tick();
        check("leds_post_reset", {28'd0, LEDs}, 32'h1);
        check_rd("rd_ctrl_rst2",  16'hD020, 8'h03);
        check_rd("rd_blink_rst2", 16'hD021, 8'h1F);
        for (int i = 0; i < 4; i++) begin
            check_rd("rd_ch_rst2", 16'(16'hD022 + i), 8'h00);
        end
        count_window(64, n0, n1, n2, n12, nnz);
        check("post_rst_ch0", n0, 63);
        check("post_rst_others", nnz, 63);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
